// File: rtl/dm_ctrl.sv
// Data memory with byte/half/word stores and sign/zero-extended loads for the single-cycle MIPS datapath.
// Optional store trace is compiled in when DM_STORE_LOG_EN is defined.
module dm_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  SType,
  input  logic [2:0]  LType,
  output logic [31:0] ReadData,
  output logic        AddrErr,
  output logic        ErrSticky,
  output logic [7:0]  ErrCount
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          err_sticky_q;
  logic [7:0]    err_cnt_q;

  logic [AW-1:0] idx;
  logic          oor, st_mis, ld_mis, wr_en;
  logic [31:0]   raw, wdata, wr_word;
  logic [15:0]   half;
  logic [7:0]    byte_sel;
  logic [3:0]    be;

  assign idx = Addr[AW+1:2];
  assign oor = {1'b0, Addr} >= LIMIT;
  assign raw = mem_q[idx];

  always_comb begin
    st_mis = 1'b0;
    case (SType)
      2'd0:    st_mis = |Addr[1:0];
      2'd1:    st_mis = Addr[0];
      default: st_mis = 1'b0;
    endcase
    ld_mis = 1'b0;
    case (LType)
      3'd0:      ld_mis = |Addr[1:0];
      3'd1, 3'd2: ld_mis = Addr[0];
      default:   ld_mis = 1'b0;
    endcase
  end

  assign AddrErr = (MemWrite & (st_mis | oor)) | (MemRead & (ld_mis | oor));

  always_comb begin
    half     = Addr[1] ? raw[31:16] : raw[15:0];
    byte_sel = raw[8*Addr[1:0] +: 8];
    ReadData = '0;
    if (!AddrErr) begin
      case (LType)
        3'd0:    ReadData = raw;
        3'd1:    ReadData = {{16{half[15]}}, half};
        3'd2:    ReadData = {16'h0000, half};
        3'd3:    ReadData = {{24{byte_sel[7]}}, byte_sel};
        3'd4:    ReadData = {24'h000000, byte_sel};
        default: ReadData = '0;
      endcase
    end
  end

  // Store data is replicated across lanes so the lane mask alone picks the target bytes.
  always_comb begin
    be    = 4'b0000;
    wdata = WD;
    case (SType)
      2'd0: be = 4'b1111;
      2'd1: begin
        be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      2'd2: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{WD[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    for (int unsigned i = 0; i < 4; i++)
      wr_word[8*i +: 8] = be[i] ? wdata[8*i +: 8] : raw[8*i +: 8];
  end

  assign wr_en = MemWrite & ~AddrErr & (SType != 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++)
        mem_q[i] <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[idx] <= wr_word;
`ifdef DM_STORE_LOG_EN
        $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, wr_word);
`endif
      end
      if (AddrErr) begin
        err_sticky_q <= 1'b1;
        if (err_cnt_q != '1)
          err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

`ifndef DM_STORE_LOG_EN
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

  assign ErrSticky = err_sticky_q;
  assign ErrCount  = err_cnt_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: a byte-addressed reference model predicts each cycle's outputs.
module tb_dm_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC = '0, Addr = '0, WD = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [1:0]  SType = '0;
  logic [2:0]  LType = '0;
  logic [31:0] ReadData;
  logic        AddrErr, ErrSticky;
  logic [7:0]  ErrCount;

  dm_ctrl #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Addr(Addr), .WD(WD),
    .MemWrite(MemWrite), .MemRead(MemRead), .SType(SType), .LType(LType),
    .ReadData(ReadData), .AddrErr(AddrErr), .ErrSticky(ErrSticky), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        sticky;
    logic [7:0]  cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [7:0] mm [BYTES];
  int  m_cnt;
  bit  m_sticky;

  function automatic int unsigned st_width(logic [1:0] st);
    case (st)
      2'd0: return 4;
      2'd1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned ld_width(logic [2:0] lt);
    case (lt)
      3'd0: return 4;
      3'd1, 3'd2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit m_err(logic mw, logic mr, logic [1:0] st, logic [2:0] lt, logic [31:0] a);
    bit oor;
    oor = (a >= BYTES);
    return (mw && ((a % st_width(st)) != 0 || oor)) || (mr && ((a % ld_width(lt)) != 0 || oor));
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] lt, logic [31:0] a);
    int unsigned b, base;
    logic [15:0] h;
    logic [7:0]  by;
    b = a % BYTES;
    case (lt)
      3'd0: begin
        base = b - (b % 4);
        return {mm[base+3], mm[base+2], mm[base+1], mm[base]};
      end
      3'd1, 3'd2: begin
        base = b - (b % 2);
        h = {mm[base+1], mm[base]};
        return (lt == 3'd1) ? 32'(signed'(h)) : {16'h0, h};
      end
      3'd3, 3'd4: begin
        by = mm[b];
        return (lt == 3'd3) ? 32'(signed'(by)) : {24'h0, by};
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic cyc(input logic rst, input logic mw, input logic mr, input logic [1:0] st,
                     input logic [2:0] lt, input logic [31:0] a, input logic [31:0] wd,
                     input bit kv, input logic [31:0] krd, input string nm);
    exp_t e;
    bit err;
    int unsigned w, base;
    @(posedge clk); #1;
    reset = rst; MemWrite = mw; MemRead = mr; SType = st; LType = lt; Addr = a; WD = wd;
    PC = PC + 32'd4;
    if (!rst) begin
      for (int i = 0; i < BYTES; i++) mm[i] = 8'h00;
      m_cnt = 0; m_sticky = 0;
    end else begin
      err = m_err(mw, mr, st, lt, a);
      e.rd = err ? 32'h0 : m_load(lt, a);
      if (kv) e.rd = krd;
      e.err = err; e.sticky = m_sticky; e.cnt = 8'(m_cnt); e.name = nm;
      q.push_back(e);
      if (mw && !err && st != 2'd3) begin
        w = st_width(st);
        base = a - (a % w);
        for (int unsigned i = 0; i < w; i++) mm[base+i] = wd[8*i +: 8];
      end
      if (err) begin
        m_sticky = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input string f, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h exp=%h", nm, f, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "ReadData",  ReadData,          e.rd);
        chk(e.name, "AddrErr",   {31'h0, AddrErr},  {31'h0, e.err});
        chk(e.name, "ErrSticky", {31'h0, ErrSticky},{31'h0, e.sticky});
        chk(e.name, "ErrCount",  {24'h0, ErrCount}, {24'h0, e.cnt});
      end
    end
  end

  initial begin
    int r;
    logic [31:0] a;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
    cyc(1, 0, 1, 0, 0, 32'h0,   0, 1, 32'h0, "rst_lw0");
    cyc(1, 0, 1, 0, 0, 32'hFFC, 0, 1, 32'h0, "rst_lwFFC");
    cyc(1, 1, 1, 0, 0, 32'h10, 32'h12345678, 1, 32'h0, "sw_same_cycle");
    cyc(1, 0, 1, 0, 0, 32'h10, 0, 1, 32'h12345678, "sw_readback");
    cyc(1, 1, 0, 2, 0, 32'h12, 32'h000000AB, 1, 32'h12345678, "sb_cycle");
    cyc(1, 1, 1, 1, 0, 32'h10, 32'h0000CDEF, 1, 32'h12AB5678, "sb_readback");
    cyc(1, 0, 1, 0, 0, 32'h10, 0, 1, 32'h12ABCDEF, "sh_readback");
    cyc(1, 1, 0, 0, 0, 32'h20, 32'h80FF7F01, 0, 0, "sw_ext");
    cyc(1, 0, 1, 0, 3, 32'h23, 0, 1, 32'hFFFFFF80, "lb23");
    cyc(1, 0, 1, 0, 4, 32'h23, 0, 1, 32'h00000080, "lbu23");
    cyc(1, 0, 1, 0, 1, 32'h20, 0, 1, 32'h00007F01, "lh20");
    cyc(1, 0, 1, 0, 1, 32'h22, 0, 1, 32'hFFFF80FF, "lh22");
    cyc(1, 0, 1, 0, 2, 32'h22, 0, 1, 32'h000080FF, "lhu22");
    cyc(1, 0, 1, 0, 5, 32'h20, 0, 1, 32'h0, "lt_reserved");
    cyc(1, 1, 0, 0, 0, 32'h22, 32'h11111111, 1, 32'h0, "sw_misaligned");
    cyc(1, 0, 1, 0, 0, 32'h20, 0, 1, 32'h80FF7F01, "after_bad_sw");
    cyc(1, 0, 1, 0, 0, 32'h1000, 0, 1, 32'h0, "lw_oor");
    cyc(1, 0, 1, 0, 0, 32'h20, 0, 1, 32'h80FF7F01, "cnt2");
    for (int i = 0; i < 300; i++) cyc(1, 0, 1, 0, 0, 32'h1001, 0, 1, 32'h0, "err_burst");
    cyc(1, 0, 1, 0, 0, 32'h10, 0, 1, 32'h12ABCDEF, "cnt_sat");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 63));
      else if (r == 8) a = 32'h0FF8 + 32'($urandom_range(0, 15));
      else             a = $urandom;
      cyc(($urandom_range(0, 199) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
          3'($urandom_range(0, 7)), a, $urandom, 0, 0, "rand");
    end
    cyc(1, 1, 0, 0, 0, 32'h4, 32'h01020304, 0, 0, "pre_rst_sw");
    cyc(0, 1, 0, 0, 0, 32'h4, 32'hDEADBEEF, 0, 0, "rst_with_sw");
    cyc(1, 0, 1, 0, 0, 32'h4, 0, 1, 32'h0, "rst_priority");
    cyc(1, 0, 1, 0, 0, 32'h4, 0, 1, 32'h0, "rst_priority2");
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Data memory with sub-word access for the single-cycle MIPS datapath. Sits directly upstream of the write-back select stage. It takes the ALU result as the byte address and `RD2` as store data. It produces the `ReadData` word that write-back selects when `MemtoReg` is 1. Stores are synchronous, with byte-lane masking; loads are combinational, with sign or zero extension.

## Interface
- `DEPTH_WORDS`, 1024 — number of 32-bit words; must be a power of two. Valid byte addresses are 0 .. 4·DEPTH_WORDS−1.
- `clk` input 1 — clock; all state updates on the rising edge.
- `reset` input 1 — synchronous, active-low; `reset`==0 at a rising edge clears the memory and the error state.
- `PC` input 32 — address of the current instruction; used only for the store log.
- `Addr` input 32 — byte address, taken from `ALUResult`.
- `WD` input 32 — store data, taken from `RD2`; the low bits are used for sub-word stores.
- `MemWrite` input 1 — store enable.
- `MemRead` input 1 — load qualifier; used only for error detection.
- `SType` input 2 — store width: 0 = word, 1 = half, 2 = byte, 3 = reserved (treated as no store).
- `LType` input 3 — load type: 0 = lw, 1 = lh, 2 = lhu, 3 = lb, 4 = lbu, 5–7 = reserved (result 0).
- `ReadData` output 32 — extended load result.
- `AddrErr` output 1 — combinational flag; the current access is misaligned or out of range.
- `ErrSticky` output 1 — registered; set by any `AddrErr` cycle, cleared only by reset.
- `ErrCount` output 8 — registered count of erroneous cycles; saturates at 255.

## Operation
- Word index = `Addr[log2(DEPTH_WORDS)+1:2]`. Byte offset = `Addr[1:0]`.
- A word access is misaligned when `Addr[1:0]` ≠ 0. A half access is misaligned when `Addr[0]` ≠ 0. Byte accesses are always aligned.
- An access is out of range when `Addr` ≥ 4·DEPTH_WORDS.
- `AddrErr` = (`MemWrite` & (misaligned for `SType` | out of range)) | (`MemRead` & (misaligned for `LType` width | out of range)).
- Store byte-lane mapping:
  - word writes all 4 lanes;
  - half writes lanes {1,0} when `Addr[1]`=0 and lanes {3,2} when `Addr[1]`=1, using `WD[15:0]`;
  - byte writes lane `Addr[1:0]` with `WD[7:0]`;
  - unselected lanes keep their old value.
- A store with `AddrErr`=1, or with `SType`=3, is suppressed; memory is unchanged.
- Load selection:
  - the raw word is the array word at the index;
  - lh/lhu take the halfword chosen by `Addr[1]`;
  - lb/lbu take the byte chosen by `Addr[1:0]`;
  - lh/lb sign-extend, lhu/lbu zero-extend.
- A load with `AddrErr`=1 returns 0 on `ReadData`. `ReadData` is valid regardless of `MemRead`.

## Timing
- Reset (`reset`=0 at an edge):
  - all memory words become 0x00000000;
  - `ErrSticky` becomes 0 and `ErrCount` becomes 0;
  - reset has priority over a simultaneous store or error.
- A store commits at the rising edge on which `MemWrite`=1 and `reset`=1.
- Load latency is zero: `ReadData` reflects array contents before the current cycle's edge.
- Same-address store and load in one cycle: the load returns the old value; the new value is visible in the following cycle. There is no bypass.
- `ErrSticky` and `ErrCount` update at the edge that samples `AddrErr`=1. `ErrCount` holds at 255.
- Reset asserted mid-sequence discards any pending store in that cycle. No partial-lane state survives reset.

## Configuration
- `DM_STORE_LOG_EN` defined: every committed store prints one simulation line at the edge, in the form `@<PC hex>: *<word-aligned Addr hex> <= <full resulting word hex>`. Suppressed stores print nothing.
- `DM_STORE_LOG_EN` undefined: no display statements are compiled. Functional behaviour is identical.

## Test plan
- Reset then read: hold `reset`=0 for one edge, release, read `Addr`=0x0 and 0xFFC with lw → `ReadData`=0, `ErrSticky`=0, `ErrCount`=0.
- Word store: sw 0x12345678 @0x10, next cycle lw @0x10 → 0x12345678. In the store cycle itself, lw @0x10 → 0x00000000.
- Sub-word store: over 0x12345678 @0x10, sb `WD`=0xAB @0x12 → 0x12AB5678. Then sh `WD`=0xCDEF @0x10 → 0x12ABCDEF.
- Load extension: with 0x80FF7F01 @0x20:
  - lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080;
  - lh @0x20 → 0x00007F01; lh @0x22 → 0xFFFF80FF; lhu @0x22 → 0x000080FF.
- Errors:
  - sw @0x22 → `AddrErr`=1, memory unchanged, `ErrSticky`=1, `ErrCount`=1;
  - lw @0x1000 with `DEPTH_WORDS`=1024 → `ReadData`=0, `ErrCount`=2;
  - drive 300 consecutive error cycles → `ErrCount`=255.
- Reset priority: sw 0xDEADBEEF @0x4 in the same cycle as `reset`=0 → after release, lw @0x4 → 0, and no log line is printed with `DM_STORE_LOG_EN` defined.
